// File: rtl/sosanh_serial.sv
// sosanh_serial: bit-serial magnitude comparator.
// Operands are captured on an accepted start, scanned MSB first one bit per
// cycle, and the first differing bit decides the result. The scan always runs
// the full WIDTH cycles, so latency is fixed regardless of the operand values.
// Results are registered as X (A>B), Y (A==B), Z (A<B); exactly one is set.
//
// Handshake: start is sampled only while idle (busy=0); an accepted start
// captures A/B, busy stays high for WIDTH+1 cycles, and done pulses for one
// cycle in the last of them. start, A and B are ignored while busy=1.
module sosanh_serial #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             X,
    output logic             Y,
    output logic             Z
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_decided;
    logic             r_gt;
    logic             r_lt;
    logic             r_x;
    logic             r_y;
    logic             r_z;

    logic w_a_bit;
    logic w_b_bit;
    logic w_sign_bit;
    logic w_last;
    logic w_take;
    logic w_a_wins;
    logic w_set_gt;
    logic w_set_lt;

    // The operand shift registers always present the current bit at the MSB.
    assign w_a_bit    = r_a[WIDTH-1];
    assign w_b_bit    = r_b[WIDTH-1];
    assign w_sign_bit = SIGNED && (r_idx == IW'(WIDTH - 1));
    assign w_last     = (r_idx == '0);

    // Only the first differing bit counts; on the sign bit the sense flips
    // because a set sign bit marks the negative (smaller) operand.
    assign w_take   = ~r_decided & (w_a_bit ^ w_b_bit);
    assign w_a_wins = w_a_bit ^ w_sign_bit;
    assign w_set_gt = w_take & w_a_wins;
    assign w_set_lt = w_take & ~w_a_wins;

    // Control and scan datapath: capture, shift, and latch the first decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_idx     <= IW'(WIDTH - 1);
                        r_decided <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_a       <= {r_a[WIDTH-2:0], 1'b0};
                    r_b       <= {r_b[WIDTH-2:0], 1'b0};
                    r_idx     <= r_idx - 1'b1;
                    r_decided <= r_decided | w_take;
                    r_gt      <= r_gt | w_set_gt;
                    r_lt      <= r_lt | w_set_lt;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result registers load on the final scan edge, including the last bit's
    // decision, and then hold until the next load or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= 1'b0;
            r_y <= 1'b0;
            r_z <= 1'b0;
        end else if (r_state == S_SCAN && w_last) begin
            r_x <= r_gt | w_set_gt;
            r_y <= ~(r_decided | w_take);
            r_z <= r_lt | w_set_lt;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign X    = r_x;
    assign Y    = r_y;
    assign Z    = r_z;

endmodule

// File: tb/tb_sosanh_serial.sv
// Bench for sosanh_serial: a signed and an unsigned instance share the same
// stimulus. Table vectors, randomized operations and hand-written multi-cycle
// sequences (busy start, held start, mid-scan reset) are all checked against
// a plain integer-compare reference.
module tb_sosanh_serial;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   exp_s;  // {X,Y,Z} for the signed instance
    logic [2:0]   exp_u;  // {X,Y,Z} for the unsigned instance
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy_s, done_s, x_s, y_s, z_s;
  logic         busy_u, done_u, x_u, y_u, z_u;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  sosanh_serial #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .A(op_a), .B(op_b),
    .busy(busy_s), .done(done_s), .X(x_s), .Y(y_s), .Z(z_s)
  );

  sosanh_serial #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .A(op_a), .B(op_b),
    .busy(busy_u), .done(done_u), .X(x_u), .Y(y_u), .Z(z_u)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference: integer comparison of the two operands
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit sgn);
    int va;
    int vb;
    if (sgn) begin
      va = int'($signed(a));
      vb = int'($signed(b));
    end else begin
      va = int'(a);
      vb = int'(b);
    end
    return {va > vb, va == vb, va < vb};
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got XYZ=%b expected XYZ=%b", name, got, exp);
    end
  endtask

  // driver: one full operation with latency, busy, result and hold checks
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] es, input logic [2:0] eu,
                       input bit scramble, input string tag);
    int n;
    int busy_n;
    bit seen;
    bit seen_u;
    logic [5:0] exp;
    exp_q.push_back({es, eu});
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    seen   = 1'b0;
    seen_u = 1'b0;
    while (!seen && n <= 3 * W) begin
      if (busy_s) busy_n++;
      if (done_s) begin
        seen   = 1'b1;
        seen_u = done_u;
      end else begin
        if (scramble) begin
          op_a = W'($urandom);
          op_b = W'($urandom);
        end
        @(negedge clk);
        n++;
      end
    end
    exp = exp_q.pop_front();
    check_int({tag, ".done_seen"}, int'(seen), 1);
    check_int({tag, ".latency"}, n, W + 1);
    check_int({tag, ".busy_cycles"}, busy_n, W + 1);
    check_int({tag, ".done_u"}, int'(seen_u), 1);
    check_vec({tag, ".res_s"}, {x_s, y_s, z_s}, exp[5:3]);
    check_vec({tag, ".res_u"}, {x_u, y_u, z_u}, exp[2:0]);
    @(negedge clk);
    check_int({tag, ".done_drop"}, int'(done_s), 0);
    check_int({tag, ".busy_drop"}, int'(busy_s), 0);
    check_vec({tag, ".hold_s"}, {x_s, y_s, z_s}, exp[5:3]);
    check_vec({tag, ".hold_u"}, {x_u, y_u, z_u}, exp[2:0]);
  endtask

  // steps cycles with A/B scrambled, counting signed-instance done pulses
  task automatic run_count(input int cycles, output int dones);
    dones = 0;
    repeat (cycles) begin
      @(negedge clk);
      op_a = W'($urandom);
      op_b = W'($urandom);
      if (done_s) dones++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int d;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{a: 4'd2,  b: 4'd1, exp_s: 3'b100, exp_u: 3'b100};
    vecs[1] = '{a: 4'd9,  b: 4'd9, exp_s: 3'b010, exp_u: 3'b010};
    vecs[2] = '{a: 4'd4,  b: 4'd9, exp_s: 3'b100, exp_u: 3'b001};
    vecs[3] = '{a: 4'd15, b: 4'd0, exp_s: 3'b001, exp_u: 3'b100};
    vecs[4] = '{a: 4'd8,  b: 4'd7, exp_s: 3'b001, exp_u: 3'b100};
    vecs[5] = '{a: 4'd0,  b: 4'd7, exp_s: 3'b001, exp_u: 3'b001};
    vecs[6] = '{a: 4'd7,  b: 4'd8, exp_s: 3'b100, exp_u: 3'b001};
    vecs[7] = '{a: 4'd0,  b: 4'd0, exp_s: 3'b010, exp_u: 3'b010};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    @(negedge clk);
    @(negedge clk);
    check_int("reset.busy", int'(busy_s), 0);
    check_int("reset.done", int'(done_s), 0);
    check_vec("reset.res_s", {x_s, y_s, z_s}, 3'b000);
    check_vec("reset.res_u", {x_u, y_u, z_u}, 3'b000);
    rst = 1'b0;

    // table vectors
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_u, 1'b0, $sformatf("vec%0d", i));
    end

    // randomized operations with A/B churning during the scan
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      do_op(ra, rb, ref_cmp(ra, rb, 1'b1), ref_cmp(ra, rb, 1'b0), 1'b1,
            $sformatf("rnd%0d_a%0d_b%0d", i, ra, rb));
    end

    // start while busy is ignored; operand changes during the scan are ignored
    @(negedge clk);
    op_a  = 4'd2;
    op_b  = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a  = 4'd0;
    op_b  = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_count(3 * W, d);
    check_int("busy_start.dones", d, 1);
    check_vec("busy_start.res_s", {x_s, y_s, z_s}, 3'b100);
    check_vec("busy_start.res_u", {x_u, y_u, z_u}, 3'b100);

    // start held high retriggers every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1;
    run_count(3 * (W + 2), d);
    start = 1'b0;
    check_int("held_start.dones", d, 3);
    run_count(W + 3, d);
    check_int("held_start.drain", d, 0);
    check_int("held_start.idle", int'(busy_s), 0);

    // make the result registers non-zero so the reset clear is visible
    do_op(4'd2, 4'd1, 3'b100, 3'b100, 1'b0, "pre_rst");

    // reset in the middle of a scan aborts immediately
    @(negedge clk);
    op_a  = 4'd2;
    op_b  = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_int("mid_rst.busy", int'(busy_s), 0);
    check_int("mid_rst.done", int'(done_s), 0);
    check_vec("mid_rst.res_s", {x_s, y_s, z_s}, 3'b000);
    check_vec("mid_rst.res_u", {x_u, y_u, z_u}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    run_count(W + 2, d);
    check_int("mid_rst.no_done", d, 0);
    do_op(4'd4, 4'd9, 3'b100, 3'b001, 1'b0, "post_rst");

    check_int("scoreboard.empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
